// File: rtl/uart_cmd_rx_if.sv
`default_nettype none
// ==========================================================================
// Module   : uart_cmd_rx_if
// Brief    : Command handshake (valid/ready + opcode/a/b) out of uart_cmd_rx
// Revision : 1.0
// ==========================================================================
interface uart_cmd_rx_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] opcode;
   logic [7:0] a;
   logic [7:0] b;

   modport master (
      output cmd_valid,
      output opcode,
      output a,
      output b,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  opcode,
      input  a,
      input  b,
      output cmd_ready
   );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ==========================================================================
// Module   : uart_cmd_rx
// Brief    : 8N1 UART receiver assembling 3-byte commands (header, a, b)
// Revision : 1.0
// ==========================================================================
module uart_cmd_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int TIMEOUT_CLKS = 640
) (
   input  wire logic     clock,
   input  wire logic     reset,
   input  wire logic     ena,
   input  wire logic     rx,
   uart_cmd_rx_if.master cmd,
   output logic          rx_busy,
   output logic          frame_err,
   output logic          sync_err,
   output logic          overrun_err
);

   localparam int c_half = CLKS_PER_BIT / 2;
   localparam int c_cw   = $clog2(CLKS_PER_BIT);
   localparam int c_tw   = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

   localparam logic [c_cw-1:0] c_half_last = c_cw'(c_half - 1);
   localparam logic [c_cw-1:0] c_bit_last  = c_cw'(CLKS_PER_BIT - 1);
   localparam logic [c_tw-1:0] c_tmo_last  = c_tw'(TIMEOUT_CLKS - 1);
   localparam logic [4:0]      c_hdr_tag   = 5'b10100;

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_start = 2'd1;
   localparam logic [1:0] c_data  = 2'd2;
   localparam logic [1:0] c_stop  = 2'd3;

   logic            r_rx_meta;
   logic            r_rx_s;
   logic [1:0]      r_state;
   logic [1:0]      w_state_next;
   logic [c_cw-1:0] r_cnt;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shift;

   logic            w_cnt_half;
   logic            w_cnt_last;
   logic            w_bit_idle;
   logic            w_byte_done;
   logic            w_frame_bad;

   logic [1:0]      r_idx;
   logic [2:0]      r_op_pend;
   logic [7:0]      r_a_pend;
   logic            r_valid;
   logic [2:0]      r_opcode;
   logic [7:0]      r_a;
   logic [7:0]      r_b;
   logic [c_tw-1:0] r_tmo;
   logic            w_tmo_run;
   logic            w_tmo_hit;
   logic            w_accept;

   logic            r_frame_err;
   logic            r_sync_err;
   logic            r_overrun_err;

   // rx is asynchronous; flops idle high so a reset never looks like a start bit
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else if (!ena) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   assign w_cnt_half = (r_cnt == c_half_last);
   assign w_cnt_last = (r_cnt == c_bit_last);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= c_idle;
      end else if (!ena) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_idle: begin
            if (!r_rx_s) begin
               w_state_next = c_start;
            end
         end
         c_start: begin
            if (w_cnt_half) begin
               w_state_next = r_rx_s ? c_idle : c_data;
            end
         end
         c_data: begin
            if (w_cnt_last && (r_bit_idx == 3'd7)) begin
               w_state_next = c_stop;
            end
         end
         c_stop: begin
            if (w_cnt_last) begin
               w_state_next = c_idle;
            end
         end
         default: w_state_next = c_idle;
      endcase
   end

   always_comb begin
      w_bit_idle  = (r_state == c_idle);
      w_byte_done = 1'b0;
      w_frame_bad = 1'b0;
      if ((r_state == c_stop) && w_cnt_last) begin
         w_byte_done = r_rx_s;
         w_frame_bad = !r_rx_s;
      end
   end

   // Bit timing counter and LSB-first data capture at mid-bit
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt     <= '0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
      end else if (!ena) begin
         r_cnt     <= '0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
      end else begin
         case (r_state)
            c_idle: begin
               r_cnt     <= '0;
               r_bit_idx <= 3'd0;
            end
            c_start: begin
               r_cnt     <= w_cnt_half ? '0 : r_cnt + 1'b1;
               r_bit_idx <= 3'd0;
            end
            c_data: begin
               if (w_cnt_last) begin
                  r_cnt              <= '0;
                  r_shift[r_bit_idx] <= r_rx_s;
                  r_bit_idx          <= r_bit_idx + 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            c_stop: begin
               r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
            end
            default: begin
               r_cnt     <= '0;
               r_bit_idx <= 3'd0;
            end
         endcase
      end
   end

   // A byte is taken when no command is held or the held one leaves this cycle
   assign w_accept  = w_byte_done && (!r_valid || cmd.cmd_ready);
   assign w_tmo_run = w_bit_idle && (r_idx != 2'd0);
   assign w_tmo_hit = w_tmo_run && (r_tmo == c_tmo_last);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_tmo <= '0;
      end else if (!ena) begin
         r_tmo <= '0;
      end else if (w_tmo_run && !w_tmo_hit) begin
         r_tmo <= r_tmo + 1'b1;
      end else begin
         r_tmo <= '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_idx         <= 2'd0;
         r_op_pend     <= 3'd0;
         r_a_pend      <= 8'h00;
         r_valid       <= 1'b0;
         r_opcode      <= 3'd0;
         r_a           <= 8'h00;
         r_b           <= 8'h00;
         r_frame_err   <= 1'b0;
         r_sync_err    <= 1'b0;
         r_overrun_err <= 1'b0;
      end else if (!ena) begin
         r_idx         <= 2'd0;
         r_op_pend     <= 3'd0;
         r_a_pend      <= 8'h00;
         r_valid       <= 1'b0;
         r_opcode      <= 3'd0;
         r_a           <= 8'h00;
         r_b           <= 8'h00;
         r_frame_err   <= 1'b0;
         r_sync_err    <= 1'b0;
         r_overrun_err <= 1'b0;
      end else begin
         r_frame_err   <= w_frame_bad;
         r_sync_err    <= 1'b0;
         r_overrun_err <= 1'b0;

         if (r_valid && cmd.cmd_ready) begin
            r_valid <= 1'b0;
         end

         if (w_byte_done && !w_accept) begin
            r_overrun_err <= 1'b1;
         end else if (w_accept) begin
            case (r_idx)
               2'd0: begin
                  if (r_shift[7:3] == c_hdr_tag) begin
                     r_op_pend <= r_shift[2:0];
                     r_idx     <= 2'd1;
                  end else begin
                     r_sync_err <= 1'b1;
                  end
               end
               2'd1: begin
                  r_a_pend <= r_shift;
                  r_idx    <= 2'd2;
               end
               2'd2: begin
                  r_idx    <= 2'd0;
                  r_opcode <= r_op_pend;
                  r_a      <= r_a_pend;
                  r_b      <= r_shift;
                  r_valid  <= 1'b1;
               end
               default: r_idx <= 2'd0;
            endcase
         end else if (w_tmo_hit) begin
            r_sync_err <= 1'b1;
            r_idx      <= 2'd0;
            r_op_pend  <= 3'd0;
            r_a_pend   <= 8'h00;
         end
      end
   end

   assign rx_busy       = !w_bit_idle || (r_idx != 2'd0);
   assign frame_err     = r_frame_err;
   assign sync_err      = r_sync_err;
   assign overrun_err   = r_overrun_err;
   assign cmd.cmd_valid = r_valid;
   assign cmd.opcode    = r_opcode;
   assign cmd.a         = r_a;
   assign cmd.b         = r_b;

endmodule
`default_nettype wire

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- Serial command front end that sits directly upstream of the ALU/UART-TX head FSM.
- Receives 8N1 UART frames on a single rx pin and assembles 3-byte commands: header (carries opcode), operand a, operand b.
- Presents each complete command as a/b/opcode with a valid/ready handshake that drives the FSM's operand and enable inputs.
- Reports framing, sync/timeout and overrun errors as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be even and ≥4.
- TIMEOUT_CLKS, 640, idle cycles allowed between bytes of one command before the partial command is discarded.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ena  in  1  block enable; low = receiver and assembler held idle and cleared
- rx  in  1  UART serial input, idle high, asynchronous to clock
- cmd_ready  in  1  consumer accepts the current command
- cmd_valid  out  1  complete command held on a/b/opcode
- opcode  out  3  ALU opcode from header bits [2:0]
- a  out  8  operand a (byte 1)
- b  out  8  operand b (byte 2)
- rx_busy  out  1  high while the bit FSM is not IDLE or a partial command is held
- frame_err  out  1  1-cycle pulse: stop bit sampled low
- sync_err  out  1  1-cycle pulse: bad header or inter-byte timeout
- overrun_err  out  1  1-cycle pulse: byte completed while cmd_valid is high

Behaviour:
- Reset (async) and ena=0 (synchronous, each cycle) clear everything:
  - outputs: cmd_valid=0, opcode=0, a=0, b=0, rx_busy=0, all error pulses 0;
  - internal state: bit FSM to IDLE, byte index 0, all counters 0, synchronizer flops to 1.
- Reset mid-frame drops the partial frame; reception restarts at the next falling edge after release.
- Synchronizer: rx passes through 2 flops, giving rx_s. All timing below is relative to rx_s.
- Bit FSM states: IDLE, START, DATA, STOP. HALF = CLKS_PER_BIT/2.
  - IDLE: rx_s==0 → START, cnt=0.
  - START: cnt increments; at cnt==HALF-1 sample rx_s.
    - rx_s==1: false start, go to IDLE with no error.
    - rx_s==0: go to DATA, cnt=0, bit index=0.
  - DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into shift[bit index] (LSB first) and reset cnt. After bit index 7 is sampled → STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
    - rx_s==1: byte_done pulse; shift register is the byte.
    - rx_s==0: frame_err pulse, byte discarded, assembler unaffected.
    - Either way → IDLE.
- Assembler (acts on byte_done, byte index 0..2):
  - Index 0: byte[7:3] must equal 5'b10100 (header 0xA0–0xA7).
    - Match: latch opcode_pending=byte[2:0], index→1.
    - Mismatch: sync_err pulse, index stays 0.
  - Index 1: latch a_pending, index→2.
  - Index 2: index→0; same cycle, load opcode/a/b outputs from pending plus this byte.
  - cmd_valid asserts the cycle after the byte_done of byte 2.
- Handshake:
  - Transfer occurs on cmd_valid && cmd_ready at a rising edge; cmd_valid falls the next cycle.
  - opcode/a/b stay stable while cmd_valid=1 and hold their values after the transfer.
  - cmd_ready while cmd_valid=0 has no effect.
- Overrun: any byte_done while cmd_valid=1 (and not transferring in that same cycle) raises an overrun_err pulse; the byte is dropped and the index is unchanged.
  - If the transfer and byte_done coincide, the byte is accepted normally.
- Timeout: the timeout counter runs while the byte index is 1 or 2 and the bit FSM is IDLE; it clears on any exit from IDLE.
  - Reaching TIMEOUT_CLKS-1 raises a sync_err pulse and resets the index to 0; pending values are discarded.
- Error pulse arbitration: a frame_err cycle never coincides with byte_done. sync_err and overrun_err are mutually exclusive by construction.
- rx_busy = (bit FSM != IDLE) || (index != 0). Combinational from registered state.

Test Plan:
- CLKS_PER_BIT=16. Send 0xA2, 0x05, 0x03 back-to-back, cmd_ready=1 → one cmd_valid pulse of 1 cycle with opcode=2, a=0x05, b=0x03; no error pulses.
- Send 0xA7, 0xFF, 0x80 with cmd_ready=0; then send 0xA1 → cmd_valid held with opcode=7, a=0xFF, b=0x80. The 0xA1 header raises overrun_err and does not alter outputs. Raise cmd_ready → cmd_valid drops next cycle.
- Send 0x35 as header → sync_err pulse, index stays 0. Then 0xA0, 0x10, 0x20 → valid command with opcode=0, a=0x10, b=0x20.
- Send 0xA3 whose stop bit is driven low → frame_err pulse, rx_busy returns to 0, no command. Then a 6-cycle low glitch on rx → false start, no error, no byte.
- Send 0xA4, 0x11, then idle for 700 cycles → sync_err at idle cycle 640. A following 0x22 is treated as a header → sync_err.
- Assert reset mid-way through data bit 4 of byte 1 → all outputs 0 immediately. After release, 0xA5, 0x01, 0x02 → opcode=5, a=1, b=2. Repeat the test with ena pulled low instead of reset → same result.
